cpu_job_scheduler: RTL and testbench
====================================

# cpu_job_scheduler

Time-shares a single 8-bit accumulator CPU core between NUM_REQ requesters. Each requester submits a job: a 64-bit program image plus two input bytes. The scheduler arbitrates round-robin, loads the program, resets the core, runs it until halt or timeout, and returns o1/o2 to the owning requester over a valid/ready response channel. It sits between the job sources and the CPU core, and is the only driver of the core's i_mem, i1, i2 and rst inputs.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- TIMEOUT, 255: maximum RUN cycles per job (1..65535).
- clk  input  1  clock; the CPU core state advances on the same edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  job offered, one bit per requester.
- req_ready  output  NUM_REQ  one-hot; job accepted this cycle.
- req_prog  input  NUM_REQ×64  program image per requester; byte k = bits [8k+7:8k].
- req_i1, req_i2  input  NUM_REQ×8  input bytes per requester.
- rsp_valid  output  NUM_REQ  one-hot; result pending for that requester.
- rsp_ready  input  NUM_REQ  requester consumes the result.
- rsp_o1, rsp_o2  output  8  result bytes; meaningful only while rsp_valid≠0.
- rsp_timeout  output  1  result was cut off by timeout, not by halt.
- busy  output  1  state≠IDLE.
- cpu_i_mem  output  64  program to the core.
- cpu_i1, cpu_i2  output  8  inputs to the core.
- cpu_rst  output  1  core reset.
- cpu_halt  input  1  core halt flag.
- cpu_o1, cpu_o2  input  8  core outputs.

## Operation
- **Reset (rst=1)**
  - State→IDLE.
  - Latched prog/i1/i2/o1/o2/owner/counter→0.
  - rr pointer→NUM_REQ-1, so requester 0 wins first.
  - All req_ready/rsp_valid/rsp_timeout/busy outputs→0.
  - cpu_rst=1 combinationally while rst is high.
  - Reset during any state drops the in-flight job; no response is issued.
- **IDLE**
  - If any req_valid is set, the grant goes to the first set bit searching from pointer+1 with wrap.
  - req_ready[grant]=1 combinationally in that cycle.
  - On that edge: latch prog/i1/i2, set owner=grant, pointer=grant, go to LOAD.
  - req_ready is never asserted outside IDLE.
- **LOAD** (1 cycle)
  - cpu_rst=1.
  - Counter→0.
  - Go to RUN.
  - cpu_halt is ignored here, because it may still hold the previous job's value.
- **RUN**
  - cpu_rst=0.
  - When cpu_halt=1: capture cpu_o1/o2, timeout=0, go to RESP.
  - Else if counter==TIMEOUT-1: capture cpu_o1/o2, timeout=1, go to RESP.
  - Else counter++.
  - When halt and the timeout limit occur in the same cycle, halt wins (timeout=0).
- **RESP**
  - rsp_valid[owner]=1; rsp_o1/o2/rsp_timeout are held from the captured registers.
  - When rsp_ready[owner]=1, go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- **Core inputs**
  - cpu_i_mem/i1/i2 are driven from the latched registers in every state.
  - They stay stable from LOAD through RESP.
- **Widths**
  - Counter is 16 bits unsigned.
  - Output data is captured verbatim; there is no arithmetic on data.

## Timing
- Job accepted at cycle T (IDLE handshake).
- T+1: LOAD.
- T+2: first RUN cycle; the core executes one instruction per cycle from byte 0.
- A program halting at its n-th fetched byte sets cpu_halt visible at T+2+n. rsp_valid rises at T+3+n.
- Timeout case: rsp_valid rises at T+2+TIMEOUT.
- After the rsp_ready handshake at cycle R, IDLE is at R+1. The earliest next acceptance is R+1, so there is a minimum 1-cycle bubble.
- Maximum job latency, accept to rsp_valid, is TIMEOUT+2 cycles.

## Structure
- types.sv (shared package) gets:
  - typedef Program = bit [63:0].
  - enum SchedState {IDLE, LOAD, RUN, RESP}.
  - UInt8 already exists there and is reused.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr.
  - Output: one-hot gnt.
  - Purely combinational.
- The pointer register lives in cpu_job_scheduler.

## Test plan
- **Simple job.** After reset, req0 submits prog 64'h0000_0000_0000_0705 with i1=8'h2A at T. Required:
  - req_ready[0] at T.
  - cpu_rst at T+1.
  - rsp_valid[0] at T+6 with o1=8'h2A, o2=0, timeout=0.
- **Arithmetic program.** req1 submits prog 64'h0000_0007_0306_0905 with i1=3, i2=4. Required: rsp_o1=7, timeout=0.
- **Round-robin fairness.** Both requesters hold valid continuously from reset. Required:
  - Grants alternate 0,1,0,1.
  - Each acceptance comes exactly 1 cycle after the previous rsp handshake.
- **Timeout.** TIMEOUT=16, prog 64'h0000_0000_0000_0001 (jump to 0 forever). Required:
  - rsp_valid at T+18.
  - rsp_timeout=1.
- **Backpressure.** rsp_ready[owner] is held low for 5 cycles, and the other requester's valid is high. Required:
  - rsp_valid and data stay stable.
  - req_ready stays 0 throughout.
  - The next grant follows the handshake.
- **Reset mid-RUN.** rst is asserted for 1 cycle during RUN. Required:
  - cpu_rst=1 during the reset cycle.
  - All outputs 0 in the next cycle, state IDLE.
  - No rsp_valid is ever issued for the dropped job.
  - The next job goes to requester 0.

Source files
------------

// File: rtl/cpu_job_scheduler_pkg.sv
// cpu_job_scheduler_pkg: shared types for the job scheduler slice
package cpu_job_scheduler_pkg;
    typedef logic [7:0] uint8_t;
    typedef logic [63:0] program_t;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} sched_state_e;
endpackage

// File: rtl/cpu_job_scheduler_if.sv
// cpu_job_scheduler_if: job request/response channels between requesters (master) and scheduler (slave)
interface cpu_job_scheduler_if
    import cpu_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    program_t [NUM_REQ-1:0] req_prog;
    uint8_t [NUM_REQ-1:0] req_i1, req_i2;
    uint8_t rsp_o1, rsp_o2;
    logic rsp_timeout;
    modport master (
        output req_valid, req_prog, req_i1, req_i2, rsp_ready,
        input  req_ready, rsp_valid, rsp_o1, rsp_o2, rsp_timeout
    );
    modport slave (
        input  req_valid, req_prog, req_i1, req_i2, rsp_ready,
        output req_ready, rsp_valid, rsp_o1, rsp_o2, rsp_timeout
    );
endinterface

// File: rtl/cpu_job_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request after ptr, wrapping
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0] gnt
);
    always_comb begin
        gnt = '0;
        for (int i = 1; i <= N; i++)
            if (req[(int'(ptr) + i) % N] && gnt == '0) gnt[(int'(ptr) + i) % N] = 1'b1;
    end
endmodule

// File: rtl/cpu_job_scheduler.sv
// cpu_job_scheduler: round-robin time-sharing of one accumulator core among NUM_REQ job requesters
module cpu_job_scheduler
    import cpu_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    cpu_job_scheduler_if.slave jobs,
    output logic busy,
    output program_t cpu_i_mem,
    output uint8_t cpu_i1,
    output uint8_t cpu_i2,
    output logic cpu_rst,
    input  logic cpu_halt,
    input  uint8_t cpu_o1,
    input  uint8_t cpu_o2
);
    localparam int PW = $clog2(NUM_REQ);
    sched_state_e r_state;
    logic [PW-1:0] r_ptr, r_owner, w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    program_t r_prog;
    uint8_t r_i1, r_i2, r_o1, r_o2;
    logic [15:0] r_cnt;
    logic r_timeout;
    rr_arbiter #(.N(NUM_REQ)) u_arb (.req(jobs.req_valid), .ptr(r_ptr), .gnt(w_gnt));
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_gnt[i]) w_idx = PW'(i);
    end
    assign jobs.req_ready = (r_state == IDLE && !rst) ? w_gnt : '0;
    assign jobs.rsp_valid = (r_state == RESP) ? NUM_REQ'(1) << r_owner : '0;
    assign jobs.rsp_o1 = r_o1;
    assign jobs.rsp_o2 = r_o2;
    assign jobs.rsp_timeout = r_timeout;
    assign busy = r_state != IDLE;
    assign cpu_rst = rst || r_state == LOAD;
    assign cpu_i_mem = r_prog;
    assign cpu_i1 = r_i1;
    assign cpu_i2 = r_i2;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= PW'(NUM_REQ - 1);
            r_owner <= '0;
            r_prog <= '0;
            r_i1 <= '0;
            r_i2 <= '0;
            r_o1 <= '0;
            r_o2 <= '0;
            r_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt != '0) begin
                    r_prog <= jobs.req_prog[w_idx];
                    r_i1 <= jobs.req_i1[w_idx];
                    r_i2 <= jobs.req_i2[w_idx];
                    r_owner <= w_idx;
                    r_ptr <= w_idx;
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_cnt <= '0;
                    r_state <= RUN;
                end
                RUN: if (cpu_halt || r_cnt == 16'(TIMEOUT - 1)) begin
                    r_o1 <= cpu_o1;
                    r_o2 <= cpu_o2;
                    r_timeout <= !cpu_halt;
                    r_state <= RESP;
                end else r_cnt <= r_cnt + 16'd1;
                RESP: if (jobs.rsp_ready[r_owner]) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_job_scheduler.sv
// tb_cpu_job_scheduler: directed self-checking bench with a small accumulator core model
module tb_cpu_job_scheduler;
    logic clk, rst, busy, cpu_rst, cpu_halt;
    logic [63:0] cpu_i_mem;
    logic [7:0] cpu_i1, cpu_i2, cpu_o1, cpu_o2;
    int total = 0, passed = 0, fails = 0;
    int n, g, last_hs, seen;
    logic [1:0] rr_exp [4];
    cpu_job_scheduler_if #(.NUM_REQ(2)) jobs ();
    cpu_job_scheduler #(.NUM_REQ(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .jobs(jobs), .busy(busy),
        .cpu_i_mem(cpu_i_mem), .cpu_i1(cpu_i1), .cpu_i2(cpu_i2), .cpu_rst(cpu_rst),
        .cpu_halt(cpu_halt), .cpu_o1(cpu_o1), .cpu_o2(cpu_o2)
    );
    logic [2:0] pc;
    logic [7:0] acc, b, op;
    assign op = cpu_i_mem[{pc, 3'b000} +: 8];
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            pc <= '0; acc <= '0; b <= '0; cpu_o1 <= '0; cpu_o2 <= '0; cpu_halt <= 1'b0;
        end else if (!cpu_halt) begin
            pc <= pc + 3'd1;
            case (op)
                8'h00: begin cpu_halt <= 1'b1; pc <= pc; end
                8'h01: pc <= '0;
                8'h03: acc <= acc + b;
                8'h05: acc <= cpu_i1;
                8'h06: acc <= cpu_i2;
                8'h07: cpu_o1 <= acc;
                8'h08: cpu_o2 <= acc;
                8'h09: b <= acc;
                default: ;
            endcase
        end
    end
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_rsp(inout int cnt);
        while (jobs.rsp_valid == '0 && cnt < 100) begin
            step();
            #1;
            cnt++;
        end
    endtask
    task automatic set_job(input int idx, input logic [63:0] prog, input logic [7:0] i1, input logic [7:0] i2);
        jobs.req_prog[idx] = prog;
        jobs.req_i1[idx] = i1;
        jobs.req_i2[idx] = i2;
    endtask
    initial begin
        rst = 1'b1;
        jobs.req_valid = '0;
        jobs.rsp_ready = '0;
        set_job(0, 64'h0, 8'h0, 8'h0);
        set_job(1, 64'h0, 8'h0, 8'h0);
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        step(); step(); #1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", jobs.rsp_valid, 0);
        chk("rst_rsp_timeout", jobs.rsp_timeout, 0);
        chk("rst_i_mem", cpu_i_mem, 0);
        step();
        rst = 1'b0;
        set_job(0, 64'h0000_0000_0000_0705, 8'h2A, 8'h00);
        jobs.req_valid = 2'b01;
        #1;
        chk("simple_ready", jobs.req_ready, 2'b01);
        step();
        jobs.req_valid = '0;
        #1;
        chk("simple_load_cpu_rst", cpu_rst, 1);
        chk("simple_load_ready", jobs.req_ready, 0);
        chk("simple_i_mem", cpu_i_mem, 64'h705);
        n = 1;
        wait_rsp(n);
        chk("simple_latency", n, 6);
        chk("simple_rsp_valid", jobs.rsp_valid, 2'b01);
        chk("simple_o1", jobs.rsp_o1, 8'h2A);
        chk("simple_o2", jobs.rsp_o2, 8'h00);
        chk("simple_timeout", jobs.rsp_timeout, 0);
        jobs.rsp_ready = 2'b01;
        step();
        jobs.rsp_ready = '0;
        #1;
        chk("simple_idle", busy, 0);
        set_job(1, 64'h0000_0007_0306_0905, 8'd3, 8'd4);
        jobs.req_valid = 2'b10;
        #1;
        chk("arith_ready", jobs.req_ready, 2'b10);
        step();
        jobs.req_valid = '0;
        #1;
        n = 1;
        wait_rsp(n);
        chk("arith_latency", n, 9);
        chk("arith_rsp_valid", jobs.rsp_valid, 2'b10);
        chk("arith_o1", jobs.rsp_o1, 8'd7);
        chk("arith_timeout", jobs.rsp_timeout, 0);
        jobs.rsp_ready = 2'b10;
        step();
        jobs.rsp_ready = '0;
        set_job(0, 64'h0000_0000_0000_0001, 8'h00, 8'h00);
        jobs.req_valid = 2'b01;
        #1;
        chk("tmo_ready", jobs.req_ready, 2'b01);
        step();
        jobs.req_valid = '0;
        #1;
        n = 1;
        wait_rsp(n);
        chk("tmo_latency", n, 18);
        chk("tmo_rsp_valid", jobs.rsp_valid, 2'b01);
        chk("tmo_flag", jobs.rsp_timeout, 1);
        jobs.rsp_ready = 2'b01;
        step();
        jobs.rsp_ready = '0;
        set_job(0, 64'h0000_0000_0000_0705, 8'h55, 8'h00);
        set_job(1, 64'h0000_0000_0000_0705, 8'h66, 8'h00);
        jobs.req_valid = 2'b01;
        #1;
        chk("bp_ready", jobs.req_ready, 2'b01);
        step();
        jobs.req_valid = 2'b11;
        jobs.rsp_ready = 2'b10;
        #1;
        n = 1;
        wait_rsp(n);
        chk("bp_latency", n, 6);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", jobs.rsp_valid, 2'b01);
            chk("bp_hold_o1", jobs.rsp_o1, 8'h55);
            chk("bp_hold_ready", jobs.req_ready, 0);
            step();
            #1;
        end
        jobs.rsp_ready = 2'b01;
        step();
        jobs.rsp_ready = 2'b10;
        #1;
        chk("bp_next_grant", jobs.req_ready, 2'b10);
        step();
        jobs.req_valid = '0;
        #1;
        n = 1;
        wait_rsp(n);
        chk("bp_second_o1", jobs.rsp_o1, 8'h66);
        chk("bp_second_valid", jobs.rsp_valid, 2'b10);
        step();
        jobs.rsp_ready = 2'b11;
        jobs.req_valid = 2'b11;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        g = 0;
        last_hs = -1;
        for (int c = 0; c < 200 && g < 4; c++) begin
            if (jobs.req_ready != '0) begin
                chk("rr_grant", jobs.req_ready, rr_exp[g]);
                if (g > 0) chk("rr_bubble", c - last_hs, 1);
                g++;
            end
            if ((jobs.rsp_valid & jobs.rsp_ready) != '0) last_hs = c;
            step();
        end
        chk("rr_count", g, 4);
        jobs.req_valid = '0;
        #1;
        n = 0;
        wait_rsp(n);
        step();
        set_job(0, 64'h0000_0000_0000_0001, 8'h00, 8'h00);
        jobs.req_valid = 2'b01;
        #1;
        chk("mid_ready", jobs.req_ready, 2'b01);
        step();
        jobs.req_valid = '0;
        step(); step(); step(); step();
        rst = 1'b1;
        #1;
        chk("mid_cpu_rst", cpu_rst, 1);
        step();
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_rsp_valid", jobs.rsp_valid, 0);
        chk("mid_req_ready", jobs.req_ready, 0);
        chk("mid_rsp_timeout", jobs.rsp_timeout, 0);
        chk("mid_rsp_o1", jobs.rsp_o1, 0);
        chk("mid_i_mem", cpu_i_mem, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            #1;
            if (jobs.rsp_valid != '0) seen = 1;
        end
        chk("mid_no_rsp", seen, 0);
        jobs.req_valid = 2'b11;
        #1;
        chk("mid_next_grant", jobs.req_ready, 2'b01);
        step();
        jobs.req_valid = '0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
